// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the CPU load/store stage and data_memory_lsu.
// The master drives requests; the slave (the LSU) returns one response per accepted request.
interface data_memory_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DAT_WIDTH-1:0]  req_wdata;
  logic                  rsp_valid;
  logic [DAT_WIDTH-1:0]  rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with load/store unit: byte-lane stores, extended loads,
// error flagging, fixed-latency responses and a sequential RAM clear after reset.
module data_memory_lsu #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DAT_WIDTH    = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  data_memory_lsu_if.slave bus
);
  localparam int B  = DAT_WIDTH / 8;
  localparam int LB = $clog2(B);
  localparam int LD = $clog2(DEPTH);
  // Address bits at or above this mask point outside the RAM.
  localparam logic [ADDR_WIDTH-1:0] HI_MASK = {ADDR_WIDTH{1'b1}} << (LB + LD);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [LD-1:0]        cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] mem_q [DEPTH];

  logic                 accept_s, err_s, misal_s, sign_s;
  logic [2:0]           align_mask_s;
  logic [LB-1:0]        off_s;
  logic [LD-1:0]        idx_s;
  logic [7:0]           be_base_s, be_full_s;
  logic [B-1:0]         be_s;
  logic [DAT_WIDTH-1:0] wrep_s, word_s, shifted_s, ext_s, rd_s;
  int                   nb_s, nbits_s;

  logic                 v1_q, e1_q;
  logic [DAT_WIDTH-1:0] d1_q;

  assign bus.req_ready = (state_q == RUN);
  assign accept_s      = rst_n && bus.req_valid && (state_q == RUN);

  // Clear-engine / run state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every word once, then run forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LD'(DEPTH - 1)) begin
        state_d = RUN;
      end else begin
        state_d = CLEAR;
      end
    end else begin
      state_d = RUN;
    end
  end

  // Request decode: error checks, lane enables, store replication, load extraction.
  always_comb begin
    off_s        = bus.req_addr[LB-1:0];
    idx_s        = bus.req_addr[LB +: LD];
    nb_s         = ((1 << bus.req_size) > B) ? B : (1 << bus.req_size);
    nbits_s      = 8 * nb_s;
    align_mask_s = 3'b000;
    be_base_s    = 8'h00;
    case (bus.req_size)
      2'd0:    begin align_mask_s = 3'b000; be_base_s = 8'h01; end
      2'd1:    begin align_mask_s = 3'b001; be_base_s = 8'h03; end
      2'd2:    begin align_mask_s = 3'b011; be_base_s = 8'h0F; end
      2'd3:    begin align_mask_s = 3'b111; be_base_s = 8'hFF; end
      default: begin align_mask_s = 3'b000; be_base_s = 8'h00; end
    endcase
    misal_s   = (bus.req_addr[2:0] & align_mask_s) != 3'b000;
    err_s     = misal_s || ((bus.req_addr & HI_MASK) != '0) ||
                ((bus.req_size == 2'd3) && (DAT_WIDTH == 32));
    be_full_s = be_base_s << off_s;
    be_s      = be_full_s[B-1:0];

    wrep_s = '0;
    for (int i = 0; i < B; i++) begin
      case (bus.req_size)
        2'd0:    wrep_s[8*i +: 8] = bus.req_wdata[7:0];
        2'd1:    wrep_s[8*i +: 8] = bus.req_wdata[8*(i%2) +: 8];
        2'd2:    wrep_s[8*i +: 8] = bus.req_wdata[8*(i%4) +: 8];
        2'd3:    wrep_s[8*i +: 8] = bus.req_wdata[8*(i%8) +: 8];
        default: wrep_s[8*i +: 8] = 8'h00;
      endcase
    end

    word_s    = mem_q[idx_s];
    shifted_s = word_s >> {off_s, 3'b000};
    case (bus.req_size)
      2'd0:    sign_s = shifted_s[7];
      2'd1:    sign_s = shifted_s[15];
      2'd2:    sign_s = shifted_s[31];
      2'd3:    sign_s = shifted_s[DAT_WIDTH-1];
      default: sign_s = 1'b0;
    endcase
    ext_s = '0;
    for (int j = 0; j < DAT_WIDTH; j++) begin
      if (j < nbits_s) begin
        ext_s[j] = shifted_s[j];
      end else begin
        ext_s[j] = sign_s & ~bus.req_unsigned;
      end
    end
    if (err_s || bus.req_write) begin
      rd_s = '0;
    end else begin
      rd_s = ext_s;
    end
  end

  // RAM write port, shared by the clear engine and byte-lane stores.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == CLEAR)) begin
      mem_q[cnt_q] <= '0;
    end else if (accept_s && bus.req_write && !err_s) begin
      for (int b = 0; b < B; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= wrep_s[8*b +: 8];
        end
      end
    end
  end

  // First response stage, loaded at the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= accept_s;
      e1_q <= accept_s && err_s;
      d1_q <= accept_s ? rd_s : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                 v2_q, e2_q;
      logic [DAT_WIDTH-1:0] d2_q;
      // Extra output stage for the two-cycle configuration.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          e2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v1_q;
          e2_q <= e1_q;
          d2_q <= d1_q;
        end
      end
      assign bus.rsp_valid = v2_q;
      assign bus.rsp_err   = e2_q;
      assign bus.rsp_rdata = d2_q;
    end else begin : g_lat1
      assign bus.rsp_valid = v1_q;
      assign bus.rsp_err   = e1_q;
      assign bus.rsp_rdata = d1_q;
    end
  endgenerate
endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench: a latency-1 and a latency-2 LSU receive identical traffic and are
// compared against a byte-array reference model with a response list keyed by acceptance cycle.
module tb_data_memory_lsu;
  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   clr = 0;
  int   p1 = 0;
  int   p2 = 0;
  int   n;
  exp_t exp_q[$];
  logic [7:0] mem_m [BYTES];

  data_memory_lsu_if #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) if1 ();
  data_memory_lsu_if #(.ADDR_WIDTH(32), .DAT_WIDTH(32)) if2 ();

  data_memory_lsu #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  data_memory_lsu #(.ADDR_WIDTH(32), .DAT_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour on bytes: natural alignment, range check, little-endian lanes.
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    int     nb;
    longint val;
    nb  = 1 << s;
    e   = ((a % nb) != 0) || (a >= BYTES) || (s == 2'd3);
    rd  = 32'h0;
    val = 0;
    if (!e) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mem_m[a + k] = wd[8*k +: 8];
      end else begin
        for (int k = 0; k < nb; k++) val = val | (longint'(mem_m[a + k]) << (8 * k));
        if (!u && val[8*nb-1]) val = val | -(longint'(1) << (8 * nb));
        rd = val[31:0];
      end
    end
  endtask

  task automatic check_rsp(input string tag, input int lat, input logic v,
                           input logic [31:0] d, input logic e, inout int p);
    logic ev;
    ev = (p < exp_q.size()) && ((exp_q[p].cyc + lat) == cyc);
    check_val({tag, "_valid"}, {63'd0, v}, {63'd0, ev});
    if (ev) begin
      check_val({tag, "_rdata"}, {32'd0, d}, {32'd0, exp_q[p].d});
      check_val({tag, "_err"}, {63'd0, e}, {63'd0, exp_q[p].e});
      p++;
    end
  endtask

  task automatic tick(input logic v, input logic w, input logic [31:0] a,
                      input logic [1:0] s, input logic u, input logic [31:0] d);
    logic [31:0] rd;
    logic        e;
    if1.req_valid = v; if1.req_write = w; if1.req_addr = a;
    if1.req_size = s;  if1.req_unsigned = u; if1.req_wdata = d;
    if2.req_valid = v; if2.req_write = w; if2.req_addr = a;
    if2.req_size = s;  if2.req_unsigned = u; if2.req_wdata = d;
    if (rst_n && v && (clr >= DEPTH)) begin
      model(w, a, s, u, d, rd, e);
      exp_q.push_back('{cyc: cyc, d: rd, e: e});
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      clr = 0;
      exp_q.delete();
      p1 = 0;
      p2 = 0;
      for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    end else if (clr < DEPTH) begin
      clr++;
    end
    @(negedge clk);
    check_val("ready1", {63'd0, if1.req_ready}, {63'd0, clr >= DEPTH});
    check_val("ready2", {63'd0, if2.req_ready}, {63'd0, clr >= DEPTH});
    check_rsp("lat1", 1, if1.rsp_valid, if1.rsp_rdata, if1.rsp_err, p1);
    check_rsp("lat2", 2, if2.rsp_valid, if2.rsp_rdata, if2.rsp_err, p2);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] s, input logic u);
    tick(1'b1, 1'b0, a, s, u, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    tick(1'b1, 1'b1, a, s, 1'b0, d);
  endtask

  // Release reset and count cycles until ready, offering an ignored store meanwhile.
  task automatic release_and_wait(output int cnt);
    rst_n = 1'b1;
    cnt   = 0;
    while (!if1.req_ready && cnt < 400) begin
      tick(1'b1, 1'b1, 32'h3FC, 2'd2, 1'b0, 32'hFFFF_FFFF);
      cnt++;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          r;

    rst_n = 1'b0;
    for (int i = 0; i < BYTES; i++) mem_m[i] = 8'h00;
    @(negedge clk);

    // Reset held three cycles, then clear length and cleared contents.
    repeat (3) idle();
    check_val("rst_rdata1", {32'd0, if1.rsp_rdata}, 64'd0);
    check_val("rst_err1", {63'd0, if1.rsp_err}, 64'd0);
    check_val("rst_rdata2", {32'd0, if2.rsp_rdata}, 64'd0);
    release_and_wait(n);
    check_val("clear_len", 64'(n), 64'd256);
    load(32'h3FC, 2'd2, 1'b0);
    check_val("tp_clr_3fc", {32'd0, if1.rsp_rdata}, 64'h0);

    // Word store, then sign-extended byte and zero-extended half loads.
    store(32'h10, 2'd2, 32'hDEAD_BEEF);
    load(32'h13, 2'd0, 1'b0);
    check_val("tp_lb_valid", {63'd0, if1.rsp_valid}, 64'd1);
    check_val("tp_lb", {32'd0, if1.rsp_rdata}, 64'hFFFF_FFDE);
    load(32'h12, 2'd1, 1'b1);
    check_val("tp_lhu", {32'd0, if1.rsp_rdata}, 64'h0000_DEAD);

    // Byte store merged into an existing word; load immediately after (read-after-write).
    store(32'h20, 2'd2, 32'h1122_3344);
    store(32'h21, 2'd0, 32'h0000_00A5);
    load(32'h20, 2'd2, 1'b0);
    check_val("tp_sb_merge", {32'd0, if1.rsp_rdata}, 64'h1122_A544);

    // Error cases leave the RAM untouched.
    load(32'h22, 2'd2, 1'b0);
    check_val("tp_err_lw", {32'd0, if1.rsp_err, if1.rsp_rdata[30:0]}, 64'h8000_0000);
    store(32'h23, 2'd1, 32'h0000_FFFF);
    check_val("tp_err_sh", {63'd0, if1.rsp_err}, 64'd1);
    store(32'h400, 2'd2, 32'h5555_5555);
    check_val("tp_err_oor", {63'd0, if1.rsp_err}, 64'd1);
    load(32'h20, 2'd3, 1'b0);
    check_val("tp_err_dbl", {63'd0, if1.rsp_err}, 64'd1);
    load(32'h20, 2'd2, 1'b0);
    check_val("tp_ram_kept", {32'd0, if1.rsp_rdata}, 64'h1122_A544);
    load(32'h0, 2'd2, 1'b0);
    check_val("tp_ram_kept0", {32'd0, if1.rsp_rdata}, 64'h0);

    // Four back-to-back loads seen on the latency-2 instance.
    idle();
    load(32'h10, 2'd2, 1'b0);
    check_val("lat2_gap", {63'd0, if2.rsp_valid}, 64'd0);
    load(32'h20, 2'd2, 1'b0);
    check_val("lat2_r0", {31'd0, if2.rsp_valid, if2.rsp_rdata}, 64'h1_DEAD_BEEF);
    load(32'h3FC, 2'd2, 1'b0);
    check_val("lat2_r1", {31'd0, if2.rsp_valid, if2.rsp_rdata}, 64'h1_1122_A544);
    load(32'h14, 2'd2, 1'b0);
    check_val("lat2_r2", {31'd0, if2.rsp_valid, if2.rsp_rdata}, 64'h1_0000_0000);
    idle();
    check_val("lat2_r3", {31'd0, if2.rsp_valid, if2.rsp_rdata}, 64'h1_0000_0000);
    idle();
    check_val("lat2_end", {63'd0, if2.rsp_valid}, 64'd0);

    // Reset with loads in flight: no responses, clear restarts, data gone.
    load(32'h10, 2'd2, 1'b0);
    load(32'h20, 2'd2, 1'b0);
    rst_n = 1'b0;
    idle();
    check_val("mid_rst_v1", {63'd0, if1.rsp_valid}, 64'd0);
    check_val("mid_rst_v2", {63'd0, if2.rsp_valid}, 64'd0);
    repeat (2) idle();
    release_and_wait(n);
    check_val("clear_len2", 64'(n), 64'd256);
    load(32'h10, 2'd2, 1'b0);
    check_val("mid_rst_10", {32'd0, if1.rsp_rdata}, 64'h0);
    load(32'h20, 2'd2, 1'b0);
    check_val("mid_rst_20", {32'd0, if1.rsp_rdata}, 64'h0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 600; t++) begin
      s = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 45)      a = 32'($urandom_range(0, 63));
      else if (r < 90) a = 32'($urandom_range(0, BYTES - 1));
      else if (r < 95) a = 32'($urandom_range(BYTES, BYTES + 64));
      else             a = $urandom;
      if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << s) - 32'd1);
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, s,
           1'($urandom_range(0, 1)), $urandom);
    end
    repeat (3) idle();
    check_val("all_rsp1", 64'(p1), 64'(exp_q.size()));
    check_val("all_rsp2", 64'(p2), 64'(exp_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised, byte-addressed successor to the word-addressed data memory.
- Sits between the CPU load/store stage and the on-chip data RAM.
- Supports byte/half/word/double accesses, byte-lane writes, sign/zero extension and a fixed-latency pipelined read path.
- Flags misaligned and out-of-range accesses, and zeroes the RAM on reset with a sequential clear engine.

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- DAT_WIDTH, 32: data width; 32 or 64 only.
- DEPTH, 256: number of DAT_WIDTH words; power of two, >= 2.
- READ_LATENCY, 1: cycles from request acceptance to response; 1 or 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DAT_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response pulse, one per accepted request, in order.
- rsp_rdata  out  DAT_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.

Behaviour:
Reset and clear:
- rst_n low at a clock edge forces state CLEAR, clear counter to 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- All in-flight responses are discarded. This also applies to reset mid-operation.
- CLEAR: once rst_n is high, writes 0 to word[counter] each cycle and increments the counter.
- After word DEPTH-1 is written, next state is RUN; req_ready goes 1 in the cycle after the last clear write.
- Clear takes exactly DEPTH cycles after reset release.
- RUN: req_ready = 1 permanently. There is no response backpressure.
- A request is accepted when req_valid && req_ready.

Addressing:
- B = DAT_WIDTH/8; lane offset = addr[log2(B)-1:0]; word index = addr[log2(B) +: log2(DEPTH)].

Error checks:
- Misaligned: addr not a multiple of 2^req_size.
- Out of range: any addr bit at or above log2(B)+log2(DEPTH) is set.
- Illegal size: req_size = 3 with DAT_WIDTH = 32.
- On any error the RAM is not modified; the response carries rsp_err = 1 and rsp_rdata = 0.

Stores:
- The low 8·2^size bits of req_wdata are replicated across lanes.
- Byte-enable = (2^(2^size)-1) << lane offset; only enabled bytes are written, at the acceptance edge.
- Response after READ_LATENCY cycles with rsp_rdata = 0 and rsp_err = 0.

Loads:
- The word is read from the RAM at the acceptance edge.
- The word is shifted right by 8·offset, masked to the access size, then sign- or zero-extended to DAT_WIDTH.
- READ_LATENCY = 1: rsp_valid is high in the cycle after acceptance.
- READ_LATENCY = 2: one extra output register stage is added.

Ordering and throughput:
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data.
- Back-to-back requests are allowed every cycle; responses emerge in acceptance order, one per cycle.
- Requests presented while req_ready = 0 are ignored, with no response.

Test Plan:
- Reset held 3 cycles, then released with DEPTH = 256 -> req_ready rises exactly 256 cycles after release; a load of word addr 0x3FC returns 0.
- Store word 0xDEADBEEF to 0x10, then load byte 0x13 with sign-extension and load half 0x12 with zero-extension -> returns 0xFFFFFFDE, then 0x0000DEAD, each 1 cycle after acceptance.
- Store byte 0xA5 to 0x21 over word 0x11223344 -> a word load of 0x20 returns 0x1122A544.
- Load word 0x22, store half 0x23, and access 0x400 with DEPTH = 256 -> rsp_err = 1 and rsp_rdata = 0 for each; the RAM is unchanged.
- READ_LATENCY = 2, four back-to-back loads -> four consecutive rsp_valid cycles starting 2 cycles after the first acceptance, in order.
- rst_n asserted while two loads are in flight -> no rsp_valid pulse follows; the clear sequence restarts and prior data reads back as 0.
